// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the operand-select / forwarding stage:
//   - default operand data width and register-address width
//   - register-zero address (never a forwarding target)
//   - operand-source enum, exported so debug logic can see the chosen path
//   - stage occupancy state enum
//   - helper that classifies where an operand comes from
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned RA_DEF    = 5;
    localparam int unsigned REG_ZERO  = 0;

    typedef enum logic [1:0] {
        SRC_REG = 2'd0,
        SRC_LIT = 2'd1,
        SRC_FWD = 2'd2
    } operand_src_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

    // A literal selection overrides everything; otherwise a forwarding hit
    // beats the register-file read.
    function automatic operand_src_e select_src(input logic is_lit, input logic fwd_hit);
        operand_src_e src;
        if (is_lit) begin
            src = SRC_LIT;
        end else if (fwd_hit) begin
            src = SRC_FWD;
        end else begin
            src = SRC_REG;
        end
        return src;
    endfunction

endpackage

// File: rtl/operand_bypass_mux_if.sv
// ---------------------------------------------------------------------------
// operand_bypass_mux_if
// Bundles the decode-side request, the forwarding buses and the ALU-side
// valid/ready pair of the operand bypass stage.
//   master : decode / forwarding sources / ALU (drives requests, out_ready)
//   slave  : operand_bypass_mux (drives in_ready, out_valid, a_bus, b_bus,
//            stall_cnt)
// ---------------------------------------------------------------------------
interface operand_bypass_mux_if
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned RA    = RA_DEF,
    parameter int unsigned NFWD  = 2,
    parameter int unsigned CNTW  = 16
) ();

    logic                    in_valid;
    logic                    in_ready;
    logic [RA-1:0]           rs_a;
    logic [RA-1:0]           rs_b;
    logic [WIDTH-1:0]        rega_data;
    logic [WIDTH-1:0]        regb_data;
    logic [WIDTH-1:0]        literal;
    logic                    alusrc;
    logic [NFWD-1:0]         fwd_wr_en;
    logic [NFWD*RA-1:0]      fwd_rd;
    logic [NFWD*WIDTH-1:0]   fwd_data;
    logic [NFWD-1:0]         fwd_pending;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        a_bus;
    logic [WIDTH-1:0]        b_bus;
    logic [CNTW-1:0]         stall_cnt;

    modport master (
        output in_valid, rs_a, rs_b, rega_data, regb_data, literal, alusrc,
        output fwd_wr_en, fwd_rd, fwd_data, fwd_pending, flush, out_ready,
        input  in_ready, out_valid, a_bus, b_bus, stall_cnt
    );

    modport slave (
        input  in_valid, rs_a, rs_b, rega_data, regb_data, literal, alusrc,
        input  fwd_wr_en, fwd_rd, fwd_data, fwd_pending, flush, out_ready,
        output in_ready, out_valid, a_bus, b_bus, stall_cnt
    );

endinterface

// File: rtl/fwd_select.sv
// ---------------------------------------------------------------------------
// fwd_select
// Priority scan of the forwarding channels for one source operand.
// Channel 0 is the youngest stage and wins over higher indices.
// Register 0 never matches.
// Ports:
//   i_src          source register address
//   i_reg_data     register-file read data (used when nothing matches)
//   i_fwd_wr_en    per-channel write enable
//   i_fwd_rd       per-channel destination, slice [k*RA +: RA]
//   i_fwd_data     per-channel result, slice [k*WIDTH +: WIDTH]
//   i_fwd_pending  per-channel "result not yet available"
//   o_data         selected data (forwarded or register)
//   o_hit          some channel matched
//   o_pending      the winning channel is still pending
// ---------------------------------------------------------------------------
module fwd_select
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned RA    = RA_DEF,
    parameter int unsigned NFWD  = 2
) (
    input  logic [RA-1:0]         i_src,
    input  logic [WIDTH-1:0]      i_reg_data,
    input  logic [NFWD-1:0]       i_fwd_wr_en,
    input  logic [NFWD*RA-1:0]    i_fwd_rd,
    input  logic [NFWD*WIDTH-1:0] i_fwd_data,
    input  logic [NFWD-1:0]       i_fwd_pending,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_hit,
    output logic                  o_pending
);

    logic w_src_nonzero;

    assign w_src_nonzero = (i_src != RA'(REG_ZERO));

    // Scan from the oldest channel down so the youngest match is applied
    // last; a pending flag therefore only survives if it belongs to the
    // winning channel (a shadowed pending match does not stall).
    always_comb begin
        o_data    = i_reg_data;
        o_hit     = 1'b0;
        o_pending = 1'b0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (w_src_nonzero && i_fwd_wr_en[k] && (i_fwd_rd[k*RA +: RA] == i_src)) begin
                o_data    = i_fwd_data[k*WIDTH +: WIDTH];
                o_hit     = 1'b1;
                o_pending = i_fwd_pending[k];
            end else begin
                // non-matching channel leaves the current choice in place
            end
        end
    end

endmodule

// File: rtl/operand_bypass_mux.sv
// ---------------------------------------------------------------------------
// operand_bypass_mux
// Registered operand-select and forwarding stage between register-file read
// and the ALU. Picks A from register/forwarded data and B from
// literal/register/forwarded data, stalls on a use of a pending result, and
// holds the pair in a valid/ready register.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   operand_bypass_mux_if.slave (decode request, forwarding buses,
//         ALU handshake, a_bus/b_bus, stall_cnt)
// Configuration macro:
//   FWD_EN  defined   -> forwarding, hazard detection, stall counting active
//           undefined -> operands come straight from register file/literal,
//                        hazard is never raised, stall_cnt stays 0
// ---------------------------------------------------------------------------
module operand_bypass_mux
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned RA    = RA_DEF,
    parameter int unsigned NFWD  = 2,
    parameter int unsigned CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    operand_bypass_mux_if.slave   bus
);

    logic [NFWD-1:0]  w_fwd_wr_en;
    logic [WIDTH-1:0] w_a_sel_data;
    logic [WIDTH-1:0] w_b_sel_data;
    logic             w_a_hit;
    logic             w_b_hit;
    logic             w_a_pend;
    logic             w_b_pend;
    logic             w_hazard;
    logic             w_in_ready;
    logic             w_capture;
    operand_src_e     w_a_src;
    operand_src_e     w_b_src;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    stage_state_e     w_state_nxt;

    stage_state_e     r_state;
    logic [WIDTH-1:0] r_a_bus;
    logic [WIDTH-1:0] r_b_bus;
    logic [CNTW-1:0]  r_stall_cnt;

`ifdef FWD_EN
    assign w_fwd_wr_en = bus.fwd_wr_en;
`else
    // With no write enables the selectors never hit, so operands fall back
    // to register data and no hazard can be raised.
    logic w_unused_fwd_wr_en;
    assign w_fwd_wr_en        = '0;
    assign w_unused_fwd_wr_en = ^bus.fwd_wr_en;
`endif

    fwd_select #(.WIDTH(WIDTH), .RA(RA), .NFWD(NFWD)) u_fwd_a (
        .i_src         (bus.rs_a),
        .i_reg_data    (bus.rega_data),
        .i_fwd_wr_en   (w_fwd_wr_en),
        .i_fwd_rd      (bus.fwd_rd),
        .i_fwd_data    (bus.fwd_data),
        .i_fwd_pending (bus.fwd_pending),
        .o_data        (w_a_sel_data),
        .o_hit         (w_a_hit),
        .o_pending     (w_a_pend)
    );

    fwd_select #(.WIDTH(WIDTH), .RA(RA), .NFWD(NFWD)) u_fwd_b (
        .i_src         (bus.rs_b),
        .i_reg_data    (bus.regb_data),
        .i_fwd_wr_en   (w_fwd_wr_en),
        .i_fwd_rd      (bus.fwd_rd),
        .i_fwd_data    (bus.fwd_data),
        .i_fwd_pending (bus.fwd_pending),
        .o_data        (w_b_sel_data),
        .o_hit         (w_b_hit),
        .o_pending     (w_b_pend)
    );

    // B is not a real use when the literal is selected, so its pending
    // match must not stall.
    assign w_hazard   = bus.in_valid && (w_a_pend || (!bus.alusrc && w_b_pend));
    assign w_in_ready = ((r_state == ST_EMPTY) || bus.out_ready) && !w_hazard && !bus.flush;
    assign w_capture  = bus.in_valid && w_in_ready;

    assign w_a_src = select_src(1'b0, w_a_hit);
    assign w_b_src = select_src(bus.alusrc, w_b_hit);

    // Operand source multiplexers.
    always_comb begin
        w_a_next = bus.rega_data;
        w_b_next = bus.regb_data;
        case (w_a_src)
            SRC_FWD: w_a_next = w_a_sel_data;
            SRC_REG: w_a_next = bus.rega_data;
            default: w_a_next = bus.rega_data;
        endcase
        case (w_b_src)
            SRC_LIT: w_b_next = bus.literal;
            SRC_FWD: w_b_next = w_b_sel_data;
            SRC_REG: w_b_next = bus.regb_data;
            default: w_b_next = bus.regb_data;
        endcase
    end

    // Occupancy next-state: flush empties the stage and blocks capture.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_capture) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (bus.flush) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_capture || !bus.out_ready) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand pair register; holds its value across flush and backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_bus <= '0;
            r_b_bus <= '0;
        end else if (w_capture) begin
            r_a_bus <= w_a_next;
            r_b_bus <= w_b_next;
        end else begin
            r_a_bus <= r_a_bus;
            r_b_bus <= r_b_bus;
        end
    end

    // Saturating hazard-stall counter; flush does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && (r_stall_cnt != {CNTW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNTW'(1);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_FULL);
    assign bus.a_bus     = r_a_bus;
    assign bus.b_bus     = r_b_bus;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_operand_bypass_mux.sv
// ---------------------------------------------------------------------------
// tb_operand_bypass_mux
// Directed scenarios followed by random traffic, each cycle compared against
// a transaction-level reference model of the operand stage. Forwarding
// expectations follow FWD_EN the same way the design build does.
// ---------------------------------------------------------------------------
module tb_operand_bypass_mux;

    localparam int W  = 32;
    localparam int RA = 5;
    localparam int NF = 2;
    localparam int CW = 16;

`ifdef FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int nvec  = 0;
    int nfail = 0;

    // reference model state
    bit          m_valid = 1'b0;
    logic [W-1:0] m_a    = '0;
    logic [W-1:0] m_b    = '0;
    int          m_cnt   = 0;

    operand_bypass_mux_if #(.WIDTH(W), .RA(RA), .NFWD(NF), .CNTW(CW)) bus ();

    operand_bypass_mux #(.WIDTH(W), .RA(RA), .NFWD(NF), .CNTW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        nvec++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Youngest writer of register s among the forwarding channels.
    task automatic lookup(input logic [RA-1:0] s, output bit hit, output bit pend,
                          output logic [W-1:0] d);
        hit = 1'b0; pend = 1'b0; d = '0;
        if (FWD_ON && s != 0) begin
            for (int k = 0; k < NF; k++) begin
                if (!hit && bus.fwd_wr_en[k] && bus.fwd_rd[k*RA +: RA] == s) begin
                    hit  = 1'b1;
                    pend = bus.fwd_pending[k];
                    d    = bus.fwd_data[k*W +: W];
                end
            end
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0; bus.rs_a = '0; bus.rs_b = '0;
        bus.rega_data = '0; bus.regb_data = '0; bus.literal = '0; bus.alusrc = 1'b0;
        bus.fwd_wr_en = '0; bus.fwd_rd = '0; bus.fwd_data = '0; bus.fwd_pending = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
    endtask

    // Called at a falling edge with inputs already driven: checks in_ready,
    // advances the model over the rising edge, checks the registered outputs.
    task automatic cycle();
        bit hit_a, hit_b, pa, pb, hz, rdy;
        logic [W-1:0] da, db, ea, eb;
        #1;
        lookup(bus.rs_a, hit_a, pa, da);
        lookup(bus.rs_b, hit_b, pb, db);
        ea  = hit_a ? da : bus.rega_data;
        eb  = bus.alusrc ? bus.literal : (hit_b ? db : bus.regb_data);
        hz  = bus.in_valid && ((hit_a && pa) || (!bus.alusrc && hit_b && pb));
        rdy = (!m_valid || bus.out_ready) && !hz && !bus.flush;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
        @(posedge clk);
        if (hz && m_cnt < 65535) m_cnt++;
        if (bus.in_valid && rdy) begin
            m_valid = 1'b1; m_a = ea; m_b = eb;
        end else if (bus.flush || (m_valid && bus.out_ready)) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        chk("a_bus", bus.a_bus, m_a);
        chk("b_bus", bus.b_bus, m_b);
        chk("stall_cnt", {16'd0, bus.stall_cnt}, m_cnt[W-1:0]);
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_a_bus", bus.a_bus, 32'd0);
        chk("rst_b_bus", bus.b_bus, 32'd0);
        chk("rst_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // plain capture, literal on B
        bus.in_valid = 1'b1; bus.rs_a = 5'd3; bus.rega_data = 32'h11;
        bus.alusrc = 1'b1; bus.literal = 32'h7F;
        cycle();
        chk("cap_a", bus.a_bus, 32'h11);
        chk("cap_b", bus.b_bus, 32'h7F);
        chk("cap_valid", {31'd0, bus.out_valid}, 32'd1);

        // both channels write r5: youngest wins
        bus.alusrc = 1'b0; bus.rs_b = 5'd5; bus.regb_data = 32'hBEEF;
        bus.fwd_wr_en = 2'b11; bus.fwd_rd = {5'd5, 5'd5};
        bus.fwd_data = {32'h5555, 32'hAAAA};
        cycle();
        chk("prio_b", bus.b_bus, FWD_ON ? 32'hAAAA : 32'hBEEF);
        bus.rs_b = 5'd0; bus.fwd_rd = {5'd0, 5'd0};
        cycle();
        chk("r0_b", bus.b_bus, 32'hBEEF);

        // load-use on r4 for two cycles
        bus.rs_a = 5'd4; bus.rega_data = 32'hDEAD; bus.alusrc = 1'b1; bus.literal = 32'h0;
        bus.fwd_wr_en = 2'b01; bus.fwd_rd = {5'd0, 5'd4};
        bus.fwd_data = {32'h0, 32'h0}; bus.fwd_pending = 2'b01;
        cycle();
        cycle();
        bus.fwd_pending = 2'b00; bus.fwd_data = {32'h0, 32'h1234};
        cycle();
        chk("lu_a", bus.a_bus, FWD_ON ? 32'h1234 : 32'hDEAD);
        chk("lu_cnt", {16'd0, bus.stall_cnt}, FWD_ON ? 32'd2 : 32'd0);

        // backpressure: held pair stays put, capture as soon as ready rises
        idle();
        bus.in_valid = 1'b1; bus.rega_data = 32'h100;
        cycle();
        bus.out_ready = 1'b0; bus.rega_data = 32'h200;
        repeat (3) cycle();
        chk("bp_hold_a", bus.a_bus, 32'h100);
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_cap_a", bus.a_bus, 32'h200);

        // flush while full with a new request present
        bus.out_ready = 1'b0; bus.rega_data = 32'h300; bus.flush = 1'b1;
        cycle();
        chk("fl_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("fl_a_kept", bus.a_bus, 32'h200);
        bus.flush = 1'b0;

        // random traffic with a small register pool to force collisions
        for (int i = 0; i < 400; i++) begin
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.rs_a        = RA'($urandom_range(0, 3));
            bus.rs_b        = RA'($urandom_range(0, 3));
            bus.rega_data   = $urandom();
            bus.regb_data   = $urandom();
            bus.literal     = $urandom();
            bus.alusrc      = 1'($urandom_range(0, 1));
            bus.fwd_wr_en   = NF'($urandom_range(0, 3));
            bus.fwd_rd      = {RA'($urandom_range(0, 3)), RA'($urandom_range(0, 3))};
            bus.fwd_data    = {$urandom(), $urandom()};
            bus.fwd_pending = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
            bus.out_ready   = ($urandom_range(0, 3) != 0);
            bus.flush       = ($urandom_range(0, 15) == 0);
            cycle();
        end

        // asynchronous reset between edges
        idle();
        bus.in_valid = 1'b1; bus.rega_data = 32'hCAFE; bus.regb_data = 32'hF00D;
        cycle();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_a", bus.a_bus, 32'd0);
        chk("arst_b", bus.b_bus, 32'd0);
        chk("arst_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        m_valid = 1'b0; m_a = '0; m_b = '0; m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        cycle();
        chk("post_rst_a", bus.a_bus, 32'hCAFE);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/operand_bypass_mux.md
# operand_bypass_mux

Registered operand-select and forwarding stage between register-file read and the ALU. Generalises the single-bit literal/register B-bus select: it picks both ALU operands from register data, instruction literal, or any of NFWD forwarding channels, detects use-before-ready hazards, and holds the result in a valid/ready pipeline register feeding the ALU.

## Interface
- WIDTH, 32, operand data width
- RA, 5, register address width
- NFWD, 2, forwarding channels; index 0 is the youngest stage and has highest priority
- CNTW, 16, stall counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- rs_a, rs_b  in  RA  source register addresses
- rega_data, regb_data  in  WIDTH  register-file read data
- literal  in  WIDTH  decoded literal
- alusrc  in  1  1 = B operand is literal, 0 = register/forwarded
- fwd_wr_en  in  NFWD  channel k writes a register
- fwd_rd  in  NFWD*RA  destination of channel k, slice [k*RA +: RA]
- fwd_data  in  NFWD*WIDTH  result of channel k, slice [k*WIDTH +: WIDTH]
- fwd_pending  in  NFWD  channel k result not yet available (load in flight)
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  a_bus/b_bus hold a valid operand pair
- out_ready  in  1  ALU consumes the pair
- a_bus, b_bus  out  WIDTH  registered ALU operands
- stall_cnt  out  CNTW  saturating count of hazard-stall cycles

## Operation
- Match k for source s: fwd_wr_en[k] && fwd_rd[k] == s && s != 0. Register 0 is never forwarded.
- Operand A: data of the lowest matching k, else rega_data.
- Operand B: literal if alusrc; else the lowest matching k's data, else regb_data.
- hazard: in_valid && the lowest matching k for a *used* source has fwd_pending[k]. B is unused when alusrc=1. A pending match at a higher index is shadowed by a lower non-pending match and does not stall.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Capture on in_valid && in_ready: a_bus, b_bus, out_valid=1 load next edge.
- Held pair drained (out_valid && out_ready) with no capture: out_valid clears.
- stall_cnt increments each cycle hazard is 1 and saturates at all-ones. It is not cleared by flush.
- State is implicit in out_valid, with two states. EMPTY goes to FULL on capture. FULL stays FULL on capture with out_ready, or on !out_ready. FULL goes to EMPTY on out_ready without capture, or on flush.

## Timing
- Reset, asynchronous: out_valid=0, a_bus=0, b_bus=0, stall_cnt=0. in_ready is 1 once rst deasserts, unless a hazard or flush is present.
- Latency: 1 cycle from the capture edge to out_valid.
- Throughput: 1 per cycle when out_ready stays high and there is no hazard.
- a_bus/b_bus are stable while out_valid && !out_ready.
- Flush has priority. On the next edge out_valid=0, with no capture that cycle. Data registers keep their values.
- Hazard and !out_ready together: stall_cnt still counts, in_ready=0.
- Forwarding inputs are sampled in the capture cycle only. No operand is re-read after capture.

## Configuration
- FWD_EN defined: forwarding, hazard detection and stall_cnt are active as described above.
- FWD_EN undefined: operands are always rega_data and regb_data/literal, and hazard is tied to 0. stall_cnt is held at 0. The fwd_* ports remain present but are ignored, so software scheduling must cover dependencies.

## Structure
- Shared package cpu_pkg holds:
  - WIDTH/RA defaults
  - the register-zero address constant
  - the operand-source enum {SRC_REG, SRC_LIT, SRC_FWD}, exported for debug
- Sub-module fwd_select: one per operand. Inputs are the source address, register data and fwd_* buses. Outputs are the selected data, the hit flag and the pending flag, using a priority scan over NFWD. It is instantiated twice.

## Test plan
- Capture with no forwarding: rs_a=3, rega_data=0x11, alusrc=1, literal=0x7F, out_ready=1. Response: a_bus=0x11, b_bus=0x7F and out_valid=1 one cycle later.
- Priority: rs_b=5, alusrc=0, channel 0 and channel 1 both write r5 with 0xAAAA and 0x5555. Response: b_bus=0xAAAA. A repeat with rs_b=0 gives b_bus=regb_data.
- Load-use: rs_a=4, channel 0 pending on r4 for 2 cycles, then data 0x1234. Response: in_ready=0 for 2 cycles, stall_cnt=2, then a_bus=0x1234.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1. Response: a_bus/b_bus are unchanged and in_ready=0. When out_ready rises, capture occurs the same cycle.
- Flush while FULL with in_valid=1. Response: out_valid=0 next cycle and no capture. Asserting rst mid-stream forces all outputs to 0 immediately.
- Without FWD_EN: the load-use case gives in_ready=1, a_bus=rega_data and stall_cnt=0.
